u_update_scheduler: RTL and testbench

- Sequences the membrane-potential/beta memory path through one full timestep.
- For each row, it:
  - reads 8 potentials (16-bit) and 8 decay factors (8-bit);
  - waits for SRAM read latency;
  - accepts one 8-lane synaptic current word;
  - applies leak, integrate and fire;
  - writes the potentials back and emits the row's spike vector.
- Drives the cntrl_* inputs of the potential/beta memory controller. It sits between the layer control FSM and that controller.

---
 rtl/u_update_scheduler_pkg.sv | 33 +++
 rtl/u_update_scheduler_lif_lane.sv | 35 +++
 rtl/u_update_scheduler.sv | 175 +++++++++++++++++
 tb/tb_u_update_scheduler.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/u_update_scheduler_pkg.sv
// Shared types and constants for the potential/beta update scheduler.
// Optional build macro used by the lane: RESET_BY_SUBTRACT_EN.
package u_update_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StUpdate,
    StWrite,
    StDone
  } state_e;

  localparam int unsigned LANE_U_W   = 16;
  localparam int unsigned LANE_B_W   = 8;
  localparam int unsigned BETA_SHIFT = 8;
  localparam int unsigned PROD_W     = LANE_U_W + LANE_B_W + 1;

  localparam logic signed [LANE_U_W-1:0] U_MAX = 16'sh7fff;
  localparam logic signed [LANE_U_W-1:0] U_MIN = 16'sh8000;

  // Clamp a wide signed value to the potential range.
  function automatic logic signed [LANE_U_W-1:0] sat_u(input logic signed [PROD_W-1:0] v);
    if (!v[PROD_W-1] && (|v[PROD_W-2:LANE_U_W-1])) begin
      return U_MAX;
    end else if (v[PROD_W-1] && !(&v[PROD_W-2:LANE_U_W-1])) begin
      return U_MIN;
    end else begin
      return v[LANE_U_W-1:0];
    end
  endfunction

endpackage

// File: rtl/u_update_scheduler_lif_lane.sv
// One combinational leaky-integrate-and-fire lane: leak, integrate, saturate, fire, reset.
// RESET_BY_SUBTRACT_EN selects subtract-threshold reset instead of reset-to-zero.
module u_update_scheduler_lif_lane
  import u_update_scheduler_pkg::*;
#(
  parameter logic signed [LANE_U_W-1:0] THRESH = 16'sd4096
) (
  input  logic signed [LANE_U_W-1:0] u_i,
  input  logic        [LANE_B_W-1:0] beta_i,
  input  logic signed [LANE_U_W-1:0] cur_i,
  output logic signed [LANE_U_W-1:0] u_o,
  output logic                       spike_o
);

  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   leak;
  logic signed [PROD_W-1:0]   cur_ext;
  logic signed [PROD_W-1:0]   sum;
  logic signed [LANE_U_W-1:0] s_sat;

  always_comb begin
    prod    = u_i * $signed({1'b0, beta_i});
    leak    = prod >>> BETA_SHIFT;
    cur_ext = $signed({{(PROD_W - LANE_U_W){cur_i[LANE_U_W-1]}}, cur_i});
    sum     = leak + cur_ext;
    s_sat   = sat_u(sum);
    spike_o = (s_sat >= THRESH);
`ifdef RESET_BY_SUBTRACT_EN
    u_o = spike_o ? (s_sat - THRESH) : s_sat;
`else
    u_o = spike_o ? '0 : s_sat;
`endif
  end

endmodule

// File: rtl/u_update_scheduler.sv
// Row-by-row timestep sequencer for the potential/beta memory path (read, wait, update, write).
// Build option RESET_BY_SUBTRACT_EN changes the lane reset rule only.
module u_update_scheduler
  import u_update_scheduler_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 9,
  parameter int unsigned        NUM_ROWS = 512,
  parameter int unsigned        LANES    = 8,
  parameter int unsigned        U_W      = 16,
  parameter int unsigned        B_W      = 8,
  parameter int unsigned        SRAM_LAT = 1,
  parameter logic signed [15:0] THRESH   = 16'sd4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [LANES*U_W-1:0]  current_in,
  input  logic                  current_valid,
  output logic                  current_ready,
  output logic [ADDR_W-1:0]     cntrl_potential_read_addr,
  input  logic [LANES*U_W-1:0]  potential_read_out,
  output logic [ADDR_W-1:0]     cntrl_beta_read_addr,
  input  logic [LANES*B_W-1:0]  beta_read_out,
  output logic [LANES*U_W-1:0]  potential_write_in,
  output logic [ADDR_W-1:0]     cntrl_potential_write_addr,
  output logic                  cntrl_potential_write_we,
  output logic [LANES-1:0]      spikes_out,
  output logic                  spikes_valid,
  output logic [ADDR_W-1:0]     row_addr
);

  localparam int unsigned CntW = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      row_q, row_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic                   we_q, we_d;
  logic                   sv_q, sv_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [LANES-1:0]       spikes_q, spikes_d;
  logic [LANES*U_W-1:0]   wdata_q, wdata_d;
  logic [LANES*U_W-1:0]   pot_cap_q, pot_cap_d;
  logic [LANES*B_W-1:0]   beta_cap_q, beta_cap_d;

  logic [LANES*U_W-1:0]   lane_u;
  logic [LANES-1:0]       lane_spike;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    u_update_scheduler_lif_lane #(
      .THRESH (THRESH)
    ) u_lane (
      .u_i     (pot_cap_q[g*U_W +: U_W]),
      .beta_i  (beta_cap_q[g*B_W +: B_W]),
      .cur_i   (current_in[g*U_W +: U_W]),
      .u_o     (lane_u[g*U_W +: U_W]),
      .spike_o (lane_spike[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    spikes_d   = spikes_q;
    pot_cap_d  = pot_cap_q;
    beta_cap_d = beta_cap_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          row_d   = '0;
        end
      end
      StRead: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        // Last wait cycle is the one where read data is valid.
        if (cnt_q == CntW'(SRAM_LAT - 1)) begin
          state_d    = StUpdate;
          pot_cap_d  = potential_read_out;
          beta_cap_d = beta_read_out;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StUpdate: begin
        if (current_valid) begin
          state_d  = StWrite;
          wdata_d  = lane_u;
          spikes_d = lane_spike;
        end
      end
      StWrite: begin
        if (row_q == ADDR_W'(NUM_ROWS - 1)) begin
          state_d = StDone;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = StRead;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered, so decode them from the next state.
    rd_addr_d = row_d;
    wr_addr_d = (state_d == StWrite) ? row_d : wr_addr_q;
    we_d      = (state_d == StWrite);
    sv_d      = (state_d == StWrite);
    ready_d   = (state_d == StUpdate);
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      we_q       <= 1'b0;
      sv_q       <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      spikes_q   <= '0;
      wdata_q    <= '0;
      pot_cap_q  <= '0;
      beta_cap_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      we_q       <= we_d;
      sv_q       <= sv_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      spikes_q   <= spikes_d;
      wdata_q    <= wdata_d;
      pot_cap_q  <= pot_cap_d;
      beta_cap_q <= beta_cap_d;
    end
  end

  assign busy                       = busy_q;
  assign done                       = done_q;
  assign current_ready              = ready_q;
  assign cntrl_potential_read_addr  = rd_addr_q;
  assign cntrl_beta_read_addr       = rd_addr_q;
  assign potential_write_in         = wdata_q;
  assign cntrl_potential_write_addr = wr_addr_q;
  assign cntrl_potential_write_we   = we_q;
  assign spikes_out                 = spikes_q;
  assign spikes_valid               = sv_q;
  assign row_addr                   = row_q;

endmodule

// File: tb/tb_u_update_scheduler.sv
// Directed bench for u_update_scheduler with a small latency-modelled potential/beta memory.
module tb_u_update_scheduler;

  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned LANES    = 8;
  localparam int unsigned U_W      = 16;
  localparam int unsigned B_W      = 8;
  localparam int unsigned SRAM_LAT = 2;
  localparam int unsigned ROW_CYC  = 3 + SRAM_LAT;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [LANES*U_W-1:0] current_in;
  logic                 current_valid;
  logic                 current_ready;
  logic [ADDR_W-1:0]    pot_rd_addr;
  logic [LANES*U_W-1:0] potential_read_out;
  logic [ADDR_W-1:0]    beta_rd_addr;
  logic [LANES*B_W-1:0] beta_read_out;
  logic [LANES*U_W-1:0] potential_write_in;
  logic [ADDR_W-1:0]    wr_addr;
  logic                 we;
  logic [LANES-1:0]     spikes_out;
  logic                 spikes_valid;
  logic [ADDR_W-1:0]    row_addr;

  int n_checks = 0;
  int n_fail   = 0;

  u_update_scheduler #(
    .ADDR_W   (ADDR_W),
    .NUM_ROWS (NUM_ROWS),
    .LANES    (LANES),
    .U_W      (U_W),
    .B_W      (B_W),
    .SRAM_LAT (SRAM_LAT),
    .THRESH   (16'sd4096)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .start                      (start),
    .busy                       (busy),
    .done                       (done),
    .current_in                 (current_in),
    .current_valid              (current_valid),
    .current_ready              (current_ready),
    .cntrl_potential_read_addr  (pot_rd_addr),
    .potential_read_out         (potential_read_out),
    .cntrl_beta_read_addr       (beta_rd_addr),
    .beta_read_out              (beta_read_out),
    .potential_write_in         (potential_write_in),
    .cntrl_potential_write_addr (wr_addr),
    .cntrl_potential_write_we   (we),
    .spikes_out                 (spikes_out),
    .spikes_valid               (spikes_valid),
    .row_addr                   (row_addr)
  );

  always #5 clk = ~clk;

  // Memory model: data for an address appears SRAM_LAT cycles after it is presented.
  logic [U_W-1:0]    pot_mem  [NUM_ROWS][LANES];
  logic [B_W-1:0]    beta_mem [NUM_ROWS][LANES];
  logic [ADDR_W-1:0] pa_pipe  [SRAM_LAT];
  logic [ADDR_W-1:0] ba_pipe  [SRAM_LAT];

  always @(posedge clk) begin
    pa_pipe[0] <= pot_rd_addr;
    ba_pipe[0] <= beta_rd_addr;
    for (int i = 1; i < SRAM_LAT; i++) begin
      pa_pipe[i] <= pa_pipe[i-1];
      ba_pipe[i] <= ba_pipe[i-1];
    end
  end

  always_comb begin
    potential_read_out = '0;
    beta_read_out      = '0;
    for (int i = 0; i < LANES; i++) begin
      potential_read_out[i*U_W +: U_W] = pot_mem[int'(pa_pipe[SRAM_LAT-1]) % NUM_ROWS][i];
      beta_read_out[i*B_W +: B_W]      = beta_mem[int'(ba_pipe[SRAM_LAT-1]) % NUM_ROWS][i];
    end
  end

  // Write / pulse logs.
  logic [ADDR_W-1:0]    wr_addr_log [$];
  logic [LANES*U_W-1:0] wr_data_log [$];
  logic [LANES-1:0]     wr_spk_log  [$];
  int done_cnt = 0;
  int sv_cnt   = 0;

  always @(posedge clk) begin
    if (we) begin
      wr_addr_log.push_back(wr_addr);
      wr_data_log.push_back(potential_write_in);
      wr_spk_log.push_back(spikes_out);
    end
    if (spikes_valid) sv_cnt = sv_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int l = 0; l < LANES; l++) begin
        pot_mem[r][l]  = '0;
        beta_mem[r][l] = '0;
      end
    end
    current_in = '0;
  endtask

  // Pulses start and returns the edge count from the start edge to the edge raising done.
  task automatic run_timestep(output int cyc, output bit timed_out);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
    timed_out = !done;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, done, current_ready, we, spikes_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {busy, done, current_ready, we, spikes_valid});
    end
    n_checks++;
    if ({pot_rd_addr, beta_rd_addr, wr_addr, row_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_addrs: got %h %h %h %h expected all 0",
               pot_rd_addr, beta_rd_addr, wr_addr, row_addr);
    end
    n_checks++;
    if ({potential_write_in, spikes_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h expected 0", potential_write_in, spikes_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_row();
    int cyc;
    bit to;
    int wb, db, sb;
    clear_mem();
    for (int r = 0; r < NUM_ROWS; r++) begin
      pot_mem[r][0]  = 16'(1000 + 256 * r);
      beta_mem[r][0] = 8'd128;
      pot_mem[r][1]  = 16'hFC18;  // -1000
      beta_mem[r][1] = 8'd64;
      pot_mem[r][7]  = 16'd100;
      beta_mem[r][7] = 8'd0;
    end
    current_in[0*U_W +: U_W] = 16'd100;
    current_in[1*U_W +: U_W] = 16'hFFFB;  // -5
    current_in[7*U_W +: U_W] = 16'd4096;
    current_valid = 1'b1;
    wb = wr_addr_log.size();
    db = done_cnt;
    sb = sv_cnt;
    run_timestep(cyc, to);
    n_checks++;
    if (to || cyc != int'(NUM_ROWS * ROW_CYC + 1)) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles (timeout %0d) expected %0d",
               cyc, to, NUM_ROWS * ROW_CYC + 1);
    end
    n_checks++;
    if (wr_addr_log.size() - wb != NUM_ROWS || done_cnt - db != 1 || sv_cnt - sb != NUM_ROWS) begin
      n_fail++;
      $display("FAIL basic_counts: got writes %0d done %0d spkv %0d expected %0d 1 %0d",
               wr_addr_log.size() - wb, done_cnt - db, sv_cnt - sb, NUM_ROWS, NUM_ROWS);
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (wb + r < wr_addr_log.size()) begin
        n_checks++;
        if (wr_addr_log[wb+r] !== ADDR_W'(r)) begin
          n_fail++;
          $display("FAIL basic_addr: got %0d expected %0d", wr_addr_log[wb+r], r);
        end
        n_checks++;
        if (wr_data_log[wb+r][0*U_W +: U_W] !== 16'(600 + 128 * r)) begin
          n_fail++;
          $display("FAIL basic_lane0 row%0d: got %0d expected %0d",
                   r, wr_data_log[wb+r][0 +: U_W], 600 + 128 * r);
        end
        n_checks++;
        if (wr_data_log[wb+r][1*U_W +: U_W] !== 16'hFF01 ||
            wr_data_log[wb+r][7*U_W +: U_W] !== 16'h0000) begin
          n_fail++;
          $display("FAIL basic_lane1_7 row%0d: got %h %h expected ff01 0000", r,
                   wr_data_log[wb+r][1*U_W +: U_W], wr_data_log[wb+r][7*U_W +: U_W]);
        end
        n_checks++;
        if (wr_spk_log[wb+r] !== 8'h80) begin
          n_fail++;
          $display("FAIL basic_spikes row%0d: got %h expected 80", r, wr_spk_log[wb+r]);
        end
      end
    end
  endtask

  task automatic test_fire_saturation();
    int cyc;
    bit to;
    int wb;
    logic [U_W-1:0] exp_l0;
    logic [U_W-1:0] exp_l1;
`ifdef RESET_BY_SUBTRACT_EN
    exp_l0 = 16'd88;
    exp_l1 = 16'd28671;
`else
    exp_l0 = 16'd0;
    exp_l1 = 16'd0;
`endif
    clear_mem();
    for (int r = 0; r < NUM_ROWS; r++) begin
      pot_mem[r][0] = 16'd4000;  beta_mem[r][0] = 8'd255;
      pot_mem[r][1] = 16'd32767; beta_mem[r][1] = 8'd255;
      pot_mem[r][2] = 16'hFFFD;  beta_mem[r][2] = 8'd128;
      pot_mem[r][3] = 16'h8000;  beta_mem[r][3] = 8'd255;
    end
    current_in[0*U_W +: U_W] = 16'd200;
    current_in[1*U_W +: U_W] = 16'd32767;
    current_in[3*U_W +: U_W] = 16'h8000;
    current_in[4*U_W +: U_W] = 16'd4095;
    current_valid = 1'b1;
    wb = wr_addr_log.size();
    run_timestep(cyc, to);
    n_checks++;
    if (to || wr_addr_log.size() - wb != NUM_ROWS) begin
      n_fail++;
      $display("FAIL fire_writes: got %0d writes (timeout %0d) expected %0d",
               wr_addr_log.size() - wb, to, NUM_ROWS);
    end
    for (int r = 0; r < NUM_ROWS; r += NUM_ROWS - 1) begin
      if (wb + r < wr_addr_log.size()) begin
        n_checks++;
        if (wr_data_log[wb+r][0*U_W +: U_W] !== exp_l0) begin
          n_fail++;
          $display("FAIL fire_lane0 row%0d: got %0d expected %0d",
                   r, wr_data_log[wb+r][0*U_W +: U_W], exp_l0);
        end
        n_checks++;
        if (wr_data_log[wb+r][1*U_W +: U_W] !== exp_l1) begin
          n_fail++;
          $display("FAIL sat_pos_lane1 row%0d: got %0d expected %0d",
                   r, wr_data_log[wb+r][1*U_W +: U_W], exp_l1);
        end
        n_checks++;
        if (wr_data_log[wb+r][2*U_W +: U_W] !== 16'hFFFE) begin
          n_fail++;
          $display("FAIL neg_floor_lane2 row%0d: got %h expected fffe",
                   r, wr_data_log[wb+r][2*U_W +: U_W]);
        end
        n_checks++;
        if (wr_data_log[wb+r][3*U_W +: U_W] !== 16'h8000 ||
            wr_data_log[wb+r][4*U_W +: U_W] !== 16'h0FFF) begin
          n_fail++;
          $display("FAIL sat_neg_thr_lane3_4 row%0d: got %h %h expected 8000 0fff", r,
                   wr_data_log[wb+r][3*U_W +: U_W], wr_data_log[wb+r][4*U_W +: U_W]);
        end
        n_checks++;
        if (wr_spk_log[wb+r] !== 8'h03) begin
          n_fail++;
          $display("FAIL fire_spikes row%0d: got %h expected 03", r, wr_spk_log[wb+r]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int n;
    int wb;
    clear_mem();
    for (int r = 0; r < NUM_ROWS; r++) begin
      pot_mem[r][0]  = 16'd1000;
      beta_mem[r][0] = 8'd128;
    end
    current_in[0 +: U_W] = 16'd100;
    current_valid = 1'b0;
    wb = wr_addr_log.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!current_ready && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (!current_ready) begin
      n_fail++;
      $display("FAIL stall_reach_update: got ready 0 after %0d cycles expected 1", n);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (current_ready !== 1'b1 || we !== 1'b0 || pot_rd_addr !== '0 || beta_rd_addr !== '0) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d: got ready %b we %b addrs %0d %0d expected 1 0 0 0",
                 k, current_ready, we, pot_rd_addr, beta_rd_addr);
      end
      tick();
    end
    current_valid = 1'b1;
    tick();
    n_checks++;
    if (we !== 1'b1 || spikes_valid !== 1'b1 || wr_addr !== '0 ||
        potential_write_in[0 +: U_W] !== 16'd600) begin
      n_fail++;
      $display("FAIL stall_release: got we %b sv %b addr %0d data %0d expected 1 1 0 600",
               we, spikes_valid, wr_addr, potential_write_in[0 +: U_W]);
    end
    n_checks++;
    if (wr_addr_log.size() - wb != 0) begin
      n_fail++;
      $display("FAIL stall_no_early_write: got %0d writes expected 0", wr_addr_log.size() - wb);
    end
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL stall_done: got done 0 expected 1");
    end
    tick();
  endtask

  task automatic test_reset_and_start();
    int n;
    int wb;
    int db;
    int cnt2;
    clear_mem();
    current_valid = 1'b1;
    wb = wr_addr_log.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(we && wr_addr == 1) && n < 100) begin
      tick();
      n++;
    end
    tick();
    n_checks++;
    if (row_addr !== 9'd2) begin
      n_fail++;
      $display("FAIL rst_row2_read: got %0d expected 2", row_addr);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({busy, we, spikes_valid, current_ready, done} !== 5'b0 || row_addr !== '0 ||
        pot_rd_addr !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_row: got ctrl %b row %0d rd %0d expected 0 0 0",
               {busy, we, spikes_valid, current_ready, done}, row_addr, pot_rd_addr);
    end
    for (int k = 0; k < 10; k++) tick();
    cnt2 = 0;
    for (int i = wb; i < wr_addr_log.size(); i++) if (wr_addr_log[i] == 9'd2) cnt2++;
    n_checks++;
    if (wr_addr_log.size() - wb != 2 || cnt2 != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_row2_write: got writes %0d row2 %0d busy %b expected 2 0 0",
               wr_addr_log.size() - wb, cnt2, busy);
    end
    wb = wr_addr_log.size();
    db = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    for (int k = 0; k < 30; k++) tick();
    n_checks++;
    if (wr_addr_log.size() - wb != NUM_ROWS || done_cnt - db != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got writes %0d done %0d busy %b expected %0d 1 0",
               wr_addr_log.size() - wb, done_cnt - db, busy, NUM_ROWS);
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (wb + r < wr_addr_log.size()) begin
        n_checks++;
        if (wr_addr_log[wb+r] !== ADDR_W'(r)) begin
          n_fail++;
          $display("FAIL busy_start_seq: got %0d expected %0d", wr_addr_log[wb+r], r);
        end
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    current_valid = 1'b0;
    current_in    = '0;
    for (int i = 0; i < SRAM_LAT; i++) begin
      pa_pipe[i] = '0;
      ba_pipe[i] = '0;
    end
    clear_mem();
    test_reset();
    test_basic_row();
    test_fire_saturation();
    test_stall();
    test_reset_and_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
